// File: rtl/dataram_arbiter.sv
// Data RAM arbiter: shares the single-port data RAM between the host monitor,
// the CPU MA stage and the DMA engine. Fixed priority host > cpu > dma, with a
// starvation guard that pushes DMA ahead of the CPU and a bounded DMA burst lock.
module dataram_arbiter #(
    parameter int DWIDTH       = 12,
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [DWIDTH-1:0] host_adr,
    input  logic [31:0]       host_wdata,
    input  logic [3:0]        host_be,
    output logic              host_gnt,
    output logic              host_rvalid,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [DWIDTH-1:0] cpu_adr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic              cpu_stall,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [DWIDTH-1:0] dma_adr,
    input  logic [31:0]       dma_wdata,
    input  logic [3:0]        dma_be,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,

    output logic [31:0]       rdata,

    output logic              ram_en,
    output logic              ram_we,
    output logic [DWIDTH-1:0] ram_adr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [31:0]       ram_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

    typedef enum logic {
        S_NORM,
        S_BURST
    } state_t;

    typedef enum logic [1:0] {
        OWN_HOST,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_nxt;
    logic          rd_pend;
    owner_t        rd_owner;
    logic          any_gnt;

    // State, counters and the pending read-return tag
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_NORM;
            starve_cnt <= '0;
            beat_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= OWN_HOST;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            beat_cnt   <= beat_nxt;
            rd_pend    <= any_gnt & ~ram_we;
            if (host_gnt) begin
                rd_owner <= OWN_HOST;
            end else if (cpu_gnt) begin
                rd_owner <= OWN_CPU;
            end else if (dma_gnt) begin
                rd_owner <= OWN_DMA;
            end
        end
    end

    // Grant selection, next-state/counter update and RAM request mux
    always_comb begin
        host_gnt   = 1'b0;
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        state_nxt  = state;
        starve_nxt = starve_cnt;
        beat_nxt   = beat_cnt;
        ram_we     = 1'b0;
        ram_adr    = '0;
        ram_wdata  = '0;
        ram_be     = '0;

        if (!rst) begin
            case (state)
                S_NORM: begin
                    if (starve_cnt == STARVE_MAX && dma_req) begin
                        dma_gnt = 1'b1;
                    end else if (host_req) begin
                        host_gnt = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end else if (dma_req) begin
                        dma_gnt = 1'b1;
                    end
                end
                S_BURST: begin
                    dma_gnt = dma_req;
                end
                default: ;
            endcase
        end

        case (state)
            S_NORM: begin
                beat_nxt = '0;
                if (dma_gnt && dma_lock && (MAX_BURST > 1)) begin
                    state_nxt = S_BURST;
                    beat_nxt  = BW'(1);
                end
            end
            S_BURST: begin
                if (dma_gnt) begin
                    beat_nxt = beat_cnt + BW'(1);
                end
                if (!dma_lock || (dma_gnt && beat_nxt == BURST_MAX)) begin
                    state_nxt = S_NORM;
                end
            end
            default: state_nxt = S_NORM;
        endcase

        if (dma_gnt || !dma_req) begin
            starve_nxt = '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_nxt = starve_cnt + SW'(1);
        end

        if (host_gnt) begin
            ram_we    = host_we;
            ram_adr   = host_adr;
            ram_wdata = host_wdata;
            ram_be    = host_we ? host_be : 4'b0000;
        end else if (cpu_gnt) begin
            ram_we    = cpu_we;
            ram_adr   = cpu_adr;
            ram_wdata = cpu_wdata;
            ram_be    = cpu_we ? cpu_be : 4'b0000;
        end else if (dma_gnt) begin
            ram_we    = dma_we;
            ram_adr   = dma_adr;
            ram_wdata = dma_wdata;
            ram_be    = dma_we ? dma_be : 4'b0000;
        end
    end

    assign any_gnt     = host_gnt | cpu_gnt | dma_gnt;
    assign ram_en      = any_gnt;
    assign cpu_stall   = cpu_req & ~cpu_gnt & ~rst;
    assign host_rvalid = rd_pend & ~rst & (rd_owner == OWN_HOST);
    assign cpu_rvalid  = rd_pend & ~rst & (rd_owner == OWN_CPU);
    assign dma_rvalid  = rd_pend & ~rst & (rd_owner == OWN_DMA);
    assign rdata       = (rd_pend & ~rst) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dataram_arbiter.sv
// Self-checking bench for dataram_arbiter: queued requesters, a RAM macro
// model, a behavioural reference model and directed scenarios.
module tb_dataram_arbiter;

    localparam int DWIDTH       = 12;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_BURST    = 8;

    typedef struct {
        logic        we;
        logic [11:0] adr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req, host_we, cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [11:0] host_adr, cpu_adr, dma_adr;
    logic [31:0] host_wdata, cpu_wdata, dma_wdata;
    logic [3:0]  host_be, cpu_be, dma_be;
    logic        host_gnt, host_rvalid, cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid;
    logic [31:0] rdata;
    logic        ram_en, ram_we;
    logic [11:0] ram_adr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;

    txn_t hq[$];
    txn_t cq[$];
    txn_t dq[$];

    int n_checks = 0;
    int n_fail   = 0;

    dataram_arbiter #(
        .DWIDTH(DWIDTH), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
        .host_be(host_be), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
        .dma_be(dma_be), .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata),
        .ram_be(ram_be), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [11:0] adr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        txn_t t;
        t.we = we; t.adr = adr; t.wdata = wdata; t.be = be;
        if (port == 0) hq.push_back(t);
        else if (port == 1) cq.push_back(t);
        else dq.push_back(t);
    endtask

    task automatic wait_drain(input int bound);
        bit done = 0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (hq.size() == 0 && cq.size() == 0 && dq.size() == 0) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL drain_timeout: queues not empty after %0d cycles", bound);
        end
        repeat (2) @(negedge clk);
    endtask

    // Single-port RAM macro, one-cycle read latency
    logic [31:0] ram_mem [0:4095];
    initial begin
        ram_rdata = 32'h0;
        for (int i = 0; i < 4096; i++) ram_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_we) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_be[b]) ram_mem[ram_adr][8*b +: 8] = ram_wdata[8*b +: 8];
                end else begin
                    ram_rdata <= ram_mem[ram_adr];
                end
            end
        end
    end

    // Requesters: present the queue head, hold it until granted, idle fields are junk
    initial begin
        logic [2:0] took;
        host_req = 0; host_we = 1; host_adr = '1; host_wdata = 32'hBAD0_0000; host_be = 4'hF;
        cpu_req  = 0; cpu_we  = 1; cpu_adr  = '1; cpu_wdata  = 32'hBAD0_0001; cpu_be  = 4'hF;
        dma_req  = 0; dma_we  = 1; dma_adr  = '1; dma_wdata  = 32'hBAD0_0002; dma_be  = 4'hF;
        forever begin
            txn_t dummy;
            @(negedge clk);
            took = {dma_gnt, cpu_gnt, host_gnt};
            @(posedge clk);
            #1;
            if (took[0] && hq.size() > 0) dummy = hq.pop_front();
            if (took[1] && cq.size() > 0) dummy = cq.pop_front();
            if (took[2] && dq.size() > 0) dummy = dq.pop_front();
            if (hq.size() > 0) begin
                host_req = 1; host_we = hq[0].we; host_adr = hq[0].adr; host_wdata = hq[0].wdata; host_be = hq[0].be;
            end else begin
                host_req = 0; host_we = 1; host_adr = '1; host_wdata = 32'hBAD0_0000; host_be = 4'hF;
            end
            if (cq.size() > 0) begin
                cpu_req = 1; cpu_we = cq[0].we; cpu_adr = cq[0].adr; cpu_wdata = cq[0].wdata; cpu_be = cq[0].be;
            end else begin
                cpu_req = 0; cpu_we = 1; cpu_adr = '1; cpu_wdata = 32'hBAD0_0001; cpu_be = 4'hF;
            end
            if (dq.size() > 0) begin
                dma_req = 1; dma_we = dq[0].we; dma_adr = dq[0].adr; dma_wdata = dq[0].wdata; dma_be = dq[0].be;
            end else begin
                dma_req = 0; dma_we = 1; dma_adr = '1; dma_wdata = 32'hBAD0_0002; dma_be = 4'hF;
            end
        end
    end

    // Port views indexed 0=host 1=cpu 2=dma
    logic        p_req [3];
    logic        p_we  [3];
    logic [11:0] p_adr [3];
    logic [31:0] p_wd  [3];
    logic [3:0]  p_be  [3];
    assign p_req[0] = host_req; assign p_req[1] = cpu_req; assign p_req[2] = dma_req;
    assign p_we[0]  = host_we;  assign p_we[1]  = cpu_we;  assign p_we[2]  = dma_we;
    assign p_adr[0] = host_adr; assign p_adr[1] = cpu_adr; assign p_adr[2] = dma_adr;
    assign p_wd[0]  = host_wdata; assign p_wd[1] = cpu_wdata; assign p_wd[2] = dma_wdata;
    assign p_be[0]  = host_be;  assign p_be[1]  = cpu_be;  assign p_be[2]  = dma_be;

    // Reference model state
    logic [31:0] model_mem [int];
    bit          m_burst = 0;
    int          m_beats = 0;
    int          m_starve = 0;
    int          m_owner = -1;
    logic [31:0] m_data = 32'h0;

    function automatic logic [31:0] model_rd(input int a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    // Compare every cycle at the falling edge, advance the model at the rising edge
    initial begin
        int w;
        logic [31:0] v;
        forever begin
            @(negedge clk);
            w = -1;
            if (!rst) begin
                if (m_burst) begin
                    if (dma_req) w = 2;
                end else if (m_starve >= STARVE_LIMIT && dma_req) w = 2;
                else if (host_req) w = 0;
                else if (cpu_req) w = 1;
                else if (dma_req) w = 2;
            end
            checkOutput("grants", {29'b0, dma_gnt, cpu_gnt, host_gnt},
                        (w >= 0) ? (32'h1 << w) : 32'h0);
            checkOutput("rvalids", {29'b0, dma_rvalid, cpu_rvalid, host_rvalid},
                        (!rst && m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
            checkOutput("rdata", rdata, (!rst && m_owner >= 0) ? m_data : 32'h0);
            checkOutput("ram_en_we", {30'b0, ram_en, ram_we},
                        (w >= 0) ? {30'b0, 1'b1, p_we[w]} : 32'h0);
            checkOutput("ram_adr", 32'(ram_adr), (w >= 0) ? 32'(p_adr[w]) : 32'h0);
            checkOutput("ram_wdata", ram_wdata, (w >= 0) ? p_wd[w] : 32'h0);
            checkOutput("ram_be", 32'(ram_be), (w >= 0 && p_we[w]) ? 32'(p_be[w]) : 32'h0);
            checkOutput("cpu_stall", 32'(cpu_stall), 32'(!rst && cpu_req && w != 1));
            @(posedge clk);
            if (rst) begin
                m_burst = 0; m_beats = 0; m_starve = 0; m_owner = -1;
            end else begin
                m_owner = -1;
                if (w >= 0) begin
                    if (p_we[w]) begin
                        v = model_rd(int'(p_adr[w]));
                        for (int b = 0; b < 4; b++)
                            if (p_be[w][b]) v[8*b +: 8] = p_wd[w][8*b +: 8];
                        model_mem[int'(p_adr[w])] = v;
                    end else begin
                        m_owner = w;
                        m_data  = model_rd(int'(p_adr[w]));
                    end
                end
                if (dma_req && w != 2) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
                else m_starve = 0;
                if (m_burst) begin
                    if (w == 2) m_beats++;
                    if (!dma_lock || m_beats == MAX_BURST) m_burst = 0;
                end else if (w == 2 && dma_lock && MAX_BURST > 1) begin
                    m_burst = 1;
                    m_beats = 1;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    string exp_seq = "CCCCDDDDDDDDCCCCDD-";

    initial begin
        logic [7:0] g;
        rst = 1;
        dma_lock = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset_flags", {23'b0, host_gnt, cpu_gnt, dma_gnt, host_rvalid, cpu_rvalid,
                    dma_rvalid, cpu_stall, ram_en, ram_we}, 32'h0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);

        // 1: lone cpu read
        applyStimulus(1, 0, 12'h010, 32'h0, 4'hF);
        @(negedge clk);
        checkOutput("t1_cpu_gnt", 32'(cpu_gnt), 32'h1);
        checkOutput("t1_ram_en_we", {30'b0, ram_en, ram_we}, 32'h2);
        checkOutput("t1_ram_adr", 32'(ram_adr), 32'h010);
        @(negedge clk);
        checkOutput("t1_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
        checkOutput("t1_rdata", rdata, 32'hA500_0010);
        wait_drain(50);

        // 2: all three request together
        applyStimulus(0, 0, 12'h020, 32'h0, 4'h0);
        applyStimulus(1, 0, 12'h030, 32'h0, 4'h0);
        applyStimulus(2, 0, 12'h040, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("t2_c1_gnts", {29'b0, dma_gnt, cpu_gnt, host_gnt}, 32'h1);
        checkOutput("t2_c1_stall", 32'(cpu_stall), 32'h1);
        @(negedge clk);
        checkOutput("t2_c2_gnts", {29'b0, dma_gnt, cpu_gnt, host_gnt}, 32'h2);
        checkOutput("t2_c2_rdata", rdata, 32'hA500_0020);
        @(negedge clk);
        checkOutput("t2_c3_gnts", {29'b0, dma_gnt, cpu_gnt, host_gnt}, 32'h4);
        checkOutput("t2_c3_rdata", rdata, 32'hA500_0030);
        wait_drain(50);

        // 3: starvation guard
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 12'(12'h100 + i), 32'h0, 4'h0);
        applyStimulus(2, 0, 12'h200, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("t3_cpu_first", {29'b0, dma_gnt, cpu_gnt, host_gnt}, 32'h2);
        end
        @(negedge clk);
        checkOutput("t3_dma_forced", {29'b0, dma_gnt, cpu_gnt, host_gnt}, 32'h4);
        checkOutput("t3_stall", 32'(cpu_stall), 32'h1);
        wait_drain(50);

        // 4: bounded burst
        dma_lock = 1;
        for (int i = 0; i < 14; i++) applyStimulus(1, 0, 12'(12'h280 + i), 32'h0, 4'h0);
        for (int i = 0; i < 10; i++) applyStimulus(2, 1, 12'(12'h300 + i), 32'h1000_0000 + i, 4'hF);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            g = host_gnt ? "H" : cpu_gnt ? "C" : dma_gnt ? "D" : "-";
            checkOutput($sformatf("t4_seq_%0d", i), 32'(g), 32'(exp_seq[i]));
        end
        checkOutput("t4_idle_stall", 32'(cpu_stall), 32'h1);
        @(posedge clk); #1 dma_lock = 0;
        wait_drain(100);

        // 5: reset with a read pending, then reset mid-burst
        applyStimulus(1, 0, 12'h050, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("t5_cpu_gnt", 32'(cpu_gnt), 32'h1);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        checkOutput("t5_rst_flags", {23'b0, host_gnt, cpu_gnt, dma_gnt, host_rvalid, cpu_rvalid,
                    dma_rvalid, cpu_stall, ram_en, ram_we}, 32'h0);
        checkOutput("t5_rst_rdata", rdata, 32'h0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checkOutput("t5_no_rvalid", 32'(cpu_rvalid), 32'h0);
        dma_lock = 1;
        for (int i = 0; i < 3; i++) applyStimulus(2, 1, 12'(12'h070 + i), 32'h2000_0000 + i, 4'hF);
        @(negedge clk);
        checkOutput("t5_burst_start", {29'b0, dma_gnt, cpu_gnt, host_gnt}, 32'h4);
        @(posedge clk); #1 rst = 1; dma_lock = 0;
        @(negedge clk);
        checkOutput("t5_rst_ram_en", 32'(ram_en), 32'h0);
        checkOutput("t5_rst_ram_adr", 32'(ram_adr), 32'h0);
        applyStimulus(1, 0, 12'h080, 32'h0, 4'h0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checkOutput("t5_norm_after", {29'b0, dma_gnt, cpu_gnt, host_gnt}, 32'h2);
        wait_drain(50);

        // 6: host partial write then read back
        applyStimulus(0, 1, 12'h060, 32'hDEAD_BEEF, 4'b0011);
        applyStimulus(0, 0, 12'h060, 32'h0, 4'hF);
        @(negedge clk);
        checkOutput("t6_wr_be", 32'(ram_be), 32'h3);
        checkOutput("t6_wr_we", 32'(ram_we), 32'h1);
        @(negedge clk);
        checkOutput("t6_rd_be", 32'(ram_be), 32'h0);
        @(negedge clk);
        checkOutput("t6_rvalids", {29'b0, dma_rvalid, cpu_rvalid, host_rvalid}, 32'h1);
        checkOutput("t6_rdata", rdata, 32'hA500_BEEF);
        wait_drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
